// File: rtl/ddr3_rw_arbiter.sv
// -----------------------------------------------------------------------------
// ddr3_rw_arbiter
//   Moves burst transfers between a frame write/read FIFO pair and the DDR3 MIG
//   user interface. Write bursts (write FIFO -> DDR3) and read bursts
//   (DDR3 -> read FIFO) share the command port round-robin. The FIFO fill
//   levels decide which sides are eligible. Each side has its own frame
//   address pointer. A wr_load / rd_load event restarts that pointer, but only
//   between bursts.
//
// Ports
//   clk_100, rst_n           MIG ui_clk and asynchronous active-low reset
//   init_calib_complete      MIG calibration done; dropping it aborts to INIT
//   fifo_init_ok             both FIFOs ready after their reset
//   wr_load, rd_load         asynchronous frame-restart levels
//   rd_enable                display active; reads only while high
//   wfifo_rcount             write-FIFO words available to pop
//   rfifo_wcount             read-FIFO fill level
//   wfifo_rden               pop the write FIFO on an accepted write beat
//   rfifo_wren               push to the read FIFO (read valid, one cycle late)
//   app_addr/app_cmd/app_en  MIG command; app_rdy is the MIG acceptance
//   app_wdf_wren/app_wdf_end MIG write data strobes; app_wdf_rdy accepts
//   app_rd_data_valid        MIG read data returned
//   busy                     a burst or read drain is in progress
// -----------------------------------------------------------------------------
module ddr3_rw_arbiter #(
  parameter int unsigned BURST_LEN    = 64,
  parameter int unsigned FRAME_WORDS  = 480000,
  parameter int unsigned WR_BASE      = 0,
  parameter int unsigned RD_BASE      = 0,
  parameter int unsigned RFIFO_THRESH = 1024
) (
  input  logic        clk_100,
  input  logic        rst_n,
  input  logic        init_calib_complete,
  input  logic        fifo_init_ok,
  input  logic        wr_load,
  input  logic        rd_load,
  input  logic        rd_enable,
  input  logic [10:0] wfifo_rcount,
  input  logic [10:0] rfifo_wcount,
  output logic        wfifo_rden,
  output logic        rfifo_wren,
  output logic [27:0] app_addr,
  output logic [2:0]  app_cmd,
  output logic        app_en,
  input  logic        app_rdy,
  output logic        app_wdf_wren,
  output logic        app_wdf_end,
  input  logic        app_wdf_rdy,
  input  logic        app_rd_data_valid,
  output logic        busy
);

  typedef enum logic [2:0] {S_INIT, S_ARB, S_WRITE, S_READ, S_RD_DRAIN} state_e;
  typedef enum logic {GRANT_WR, GRANT_RD} grant_e;

  state_e      state_q, state_d;
  grant_e      last_grant_q, last_grant_d;
  logic [27:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [10:0] cmd_cnt_q, cmd_cnt_d;
  logic [10:0] outstanding_q, outstanding_d;
  logic [1:0]  wr_load_sync_q, wr_load_sync_d, rd_load_sync_q, rd_load_sync_d;
  logic        wr_load_prev_q, wr_load_prev_d, rd_load_prev_q, rd_load_prev_d;
  logic        wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic        rfifo_wren_q, rfifo_wren_d;

  logic wr_req, rd_req, last_cmd, rd_issue, wr_edge, rd_edge;

  // Advance by one BL8 command (8 x16 words); wrap to base at the frame end,
  // which may happen in the middle of a burst.
  function automatic logic [27:0] next_ptr(input logic [27:0] ptr,
                                           input int unsigned base);
    logic [31:0] sum;
    sum = 32'(ptr) + 32'd8;
    if (sum >= base + FRAME_WORDS) return 28'(base);
    return sum[27:0];
  endfunction

  assign wr_req   = 32'(wfifo_rcount) >= BURST_LEN;
  assign rd_req   = rd_enable && (32'(rfifo_wcount) <= RFIFO_THRESH);
  assign last_cmd = cmd_cnt_q == 11'(BURST_LEN - 1);
  assign wr_edge  = wr_load_sync_q[1] & ~wr_load_prev_q;
  assign rd_edge  = rd_load_sync_q[1] & ~rd_load_prev_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned and no latch is inferred.
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    cmd_cnt_d      = cmd_cnt_q;
    wr_load_sync_d = {wr_load_sync_q[0], wr_load};
    rd_load_sync_d = {rd_load_sync_q[0], rd_load};
    wr_load_prev_d = wr_load_sync_q[1];
    rd_load_prev_d = rd_load_sync_q[1];
    wr_pend_d      = wr_pend_q | wr_edge;
    rd_pend_d      = rd_pend_q | rd_edge;
    rfifo_wren_d   = app_rd_data_valid;
    rd_issue       = 1'b0;
    app_en         = 1'b0;
    app_cmd        = 3'b001;
    app_addr       = '0;
    app_wdf_wren   = 1'b0;
    app_wdf_end    = 1'b0;
    wfifo_rden     = 1'b0;

    unique case (state_q)
      S_INIT: if (init_calib_complete && fifo_init_ok) state_d = S_ARB;
      S_ARB: begin
        cmd_cnt_d = '0;
        // Restarts land only here, so a burst always stays contiguous. An edge
        // arriving in this same cycle stays pending for the next ARB visit.
        if (wr_pend_q) begin
          wr_ptr_d  = 28'(WR_BASE);
          wr_pend_d = wr_edge;
        end
        if (rd_pend_q) begin
          rd_ptr_d  = 28'(RD_BASE);
          rd_pend_d = rd_edge;
        end
        if (wr_req && (!rd_req || last_grant_q == GRANT_RD)) begin
          state_d      = S_WRITE;
          last_grant_d = GRANT_WR;
        end else if (rd_req) begin
          state_d      = S_READ;
          last_grant_d = GRANT_RD;
        end
      end
      S_WRITE: begin
        app_en       = 1'b1;
        app_cmd      = 3'b000;
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        app_addr     = wr_ptr_q;
        // Command and data are presented together, so a beat moves only when
        // both the command and the data ports take it.
        if (app_rdy && app_wdf_rdy) begin
          wfifo_rden = 1'b1;
          wr_ptr_d   = next_ptr(wr_ptr_q, WR_BASE);
          cmd_cnt_d  = cmd_cnt_q + 11'd1;
          if (last_cmd) state_d = S_ARB;
        end
      end
      S_READ: begin
        app_en   = 1'b1;
        app_addr = rd_ptr_q;
        if (app_rdy) begin
          rd_issue  = 1'b1;
          rd_ptr_d  = next_ptr(rd_ptr_q, RD_BASE);
          cmd_cnt_d = cmd_cnt_q + 11'd1;
          if (last_cmd) state_d = S_RD_DRAIN;
        end
      end
      S_RD_DRAIN: if (outstanding_q == '0) state_d = S_ARB;
      default: state_d = S_INIT;
    endcase

    unique case ({rd_issue, app_rd_data_valid})
      2'b10:   outstanding_d = outstanding_q + 11'd1;
      2'b01:   outstanding_d = outstanding_q - 11'd1;
      default: outstanding_d = outstanding_q;
    endcase

    // Calibration loss overrides everything; pointers and outstanding survive.
    if (!init_calib_complete) state_d = S_INIT;
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_INIT;
      last_grant_q   <= GRANT_RD;
      wr_ptr_q       <= 28'(WR_BASE);
      rd_ptr_q       <= 28'(RD_BASE);
      cmd_cnt_q      <= '0;
      outstanding_q  <= '0;
      wr_load_sync_q <= '0;
      rd_load_sync_q <= '0;
      wr_load_prev_q <= 1'b0;
      rd_load_prev_q <= 1'b0;
      wr_pend_q      <= 1'b0;
      rd_pend_q      <= 1'b0;
      rfifo_wren_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of every other flop, independent of statement order.
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cmd_cnt_q      <= cmd_cnt_d;
      outstanding_q  <= outstanding_d;
      wr_load_sync_q <= wr_load_sync_d;
      rd_load_sync_q <= rd_load_sync_d;
      wr_load_prev_q <= wr_load_prev_d;
      rd_load_prev_q <= rd_load_prev_d;
      wr_pend_q      <= wr_pend_d;
      rd_pend_q      <= rd_pend_d;
      rfifo_wren_q   <= rfifo_wren_d;
    end
  end

  assign rfifo_wren = rfifo_wren_q;
  assign busy       = (state_q == S_WRITE) || (state_q == S_READ) ||
                      (state_q == S_RD_DRAIN);

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ddr3_rw_arbiter
//   Self-checking bench for ddr3_rw_arbiter. It uses a small frame
//   (FRAME_WORDS=1000), so both address pointers wrap in the middle of a
//   burst. RD_BASE is nonzero, so a read restart is visible. A MIG model
//   returns read data 20 cycles after each accepted read command. Expected
//   addresses are queued when a burst is set up and compared as beats are
//   accepted.
// -----------------------------------------------------------------------------
module tb_ddr3_rw_arbiter;

  localparam int unsigned BL  = 64;
  localparam int unsigned FW  = 1000;
  localparam int unsigned WB  = 0;
  localparam int unsigned RB  = 256;
  localparam int unsigned TH  = 1024;
  localparam int          LAT = 20;

  logic        clk_100 = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_calib_complete, fifo_init_ok, wr_load, rd_load, rd_enable;
  logic [10:0] wfifo_rcount, rfifo_wcount;
  logic        wfifo_rden, rfifo_wren, app_en, app_rdy, app_wdf_wren;
  logic        app_wdf_end, app_wdf_rdy, app_rd_data_valid, busy;
  logic [27:0] app_addr;
  logic [2:0]  app_cmd;

  always #5 clk_100 = ~clk_100;

  ddr3_rw_arbiter #(
    .BURST_LEN(BL), .FRAME_WORDS(FW), .WR_BASE(WB), .RD_BASE(RB),
    .RFIFO_THRESH(TH)
  ) dut (
    .clk_100(clk_100), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .fifo_init_ok(fifo_init_ok), .wr_load(wr_load), .rd_load(rd_load),
    .rd_enable(rd_enable), .wfifo_rcount(wfifo_rcount),
    .rfifo_wcount(rfifo_wcount), .wfifo_rden(wfifo_rden),
    .rfifo_wren(rfifo_wren), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_rdy(app_rdy), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid), .busy(busy)
  );

  typedef enum int {G_NONE, G_WR, G_RD} grant_t;
  typedef struct {
    logic [10:0] wcount;   // rfifo_wcount
    logic [10:0] rcount;   // wfifo_rcount
    logic        rd_en;
    int          mode;     // 0 always ready, 1 toggled ready, 2 random ready
    grant_t      exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_acc_cnt = 0, rd_acc_cnt = 0, rfifo_cnt = 0;
  logic [27:0] exp_wr_q[$], exp_rd_q[$];
  int          ret_q[$];
  logic [27:0] wr_ptr_m, rd_ptr_m;
  vec_t        vecs[11];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Address model: offset into the frame, wrapped back to base at the end.
  function automatic logic [27:0] adv(input logic [27:0] p,
                                      input int unsigned base);
    int unsigned off;
    off = int'(p) - base + 8;
    return (off >= FW) ? 28'(base) : 28'(base + off);
  endfunction

  task automatic push_wr(input int n);
    for (int i = 0; i < n; i++) begin
      exp_wr_q.push_back(wr_ptr_m);
      wr_ptr_m = adv(wr_ptr_m, WB);
    end
  endtask

  task automatic push_rd(input int n);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(rd_ptr_m);
      rd_ptr_m = adv(rd_ptr_m, RB);
    end
  endtask

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  // MIG model and scoreboard. Sampled on the falling edge, so these are the
  // values the DUT will register on the next rising edge.
  initial begin : mig_monitor
    logic        drv_valid;
    logic        wr_acc, rd_acc;
    logic [27:0] e;
    drv_valid = 1'b0;
    app_rd_data_valid = 1'b0;
    forever begin
      @(negedge clk_100);
      cyc++;
      if (rst_n) begin
        if (rfifo_wren || drv_valid) check("rfifo_wren", 32'(rfifo_wren), 32'(drv_valid));
        if (rfifo_wren) rfifo_cnt++;
        wr_acc = app_en && (app_cmd == 3'b000) && app_rdy && app_wdf_rdy;
        rd_acc = app_en && (app_cmd == 3'b001) && app_rdy;
        if (app_en || wfifo_rden) check("wfifo_rden", 32'(wfifo_rden), 32'(wr_acc));
        if (app_en)
          check("wdf_strobes", 32'({app_wdf_wren, app_wdf_end}),
                (app_cmd == 3'b000) ? 32'd3 : 32'd0);
        if (wr_acc) begin
          wr_acc_cnt++;
          if (exp_wr_q.size() == 0) check("wr_unexpected_beat", 32'(app_addr), 32'hFFFF_FFFF);
          else begin
            e = exp_wr_q.pop_front();
            check("wr_addr", 32'(app_addr), 32'(e));
          end
        end
        if (rd_acc) begin
          rd_acc_cnt++;
          ret_q.push_back(cyc + LAT);
          if (exp_rd_q.size() == 0) check("rd_unexpected_cmd", 32'(app_addr), 32'hFFFF_FFFF);
          else begin
            e = exp_rd_q.pop_front();
            check("rd_addr", 32'(app_addr), 32'(e));
          end
        end
      end
      drv_valid = 1'b0;
      if (ret_q.size() > 0 && ret_q[0] == cyc) begin
        drv_valid = 1'b1;
        void'(ret_q.pop_front());
      end
      app_rd_data_valid = drv_valid;
    end
  end

  // Waits for a grant, removes the requests, drives ready per mode until the
  // DUT is back in ARB, then checks the beat counts.
  task automatic do_burst(input grant_t kind, input int mode, input string tag);
    int  wr0, rd0, rf0, n;
    bit  got;
    wr0 = wr_acc_cnt; rd0 = rd_acc_cnt; rf0 = rfifo_cnt;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      got = busy;
    end
    check({tag, "_grant"}, 32'(got), 32'd1);
    if (!got) return;
    check({tag, "_cmd"}, 32'(app_cmd), (kind == G_WR) ? 32'd0 : 32'd1);
    wfifo_rcount = '0;
    rd_enable    = 1'b0;
    n = 0;
    while (busy && n < 3000) begin
      case (mode)
        1: if (kind == G_WR) app_wdf_rdy = ~app_wdf_rdy; else app_rdy = ~app_rdy;
        2: begin
          app_rdy     = 1'($urandom_range(0, 1));
          app_wdf_rdy = 1'($urandom_range(0, 1));
        end
        default: ;
      endcase
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(busy), 32'd0);
    if (kind == G_WR) begin
      check({tag, "_wr_beats"}, 32'(wr_acc_cnt - wr0), BL);
      check({tag, "_rd_cmds"}, 32'(rd_acc_cnt - rd0), 32'd0);
    end else begin
      check({tag, "_rd_cmds"}, 32'(rd_acc_cnt - rd0), BL);
      check({tag, "_rfifo_pushes"}, 32'(rfifo_cnt - rf0), BL);
      check({tag, "_drained"}, 32'(ret_q.size()), 32'd0);
    end
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, k, wr0;
    bit got;
    // wcount, rcount, rd_en, mode, expected grant
    vecs[0]  = '{11'd0,    11'd0,    1'b0, 0, G_NONE};
    vecs[1]  = '{11'd0,    11'd63,   1'b0, 0, G_NONE};  // one short of a burst
    vecs[2]  = '{11'd1025, 11'd0,    1'b1, 0, G_NONE};  // read FIFO above thresh
    vecs[3]  = '{11'd0,    11'd64,   1'b0, 0, G_WR};    // addresses 0..504
    vecs[4]  = '{11'd1024, 11'd64,   1'b1, 0, G_RD};    // both, last=WR; thresh edge
    vecs[5]  = '{11'd0,    11'd200,  1'b1, 1, G_WR};    // wraps 992 -> 0 mid-burst
    vecs[6]  = '{11'd0,    11'd200,  1'b1, 1, G_RD};    // wraps 1248 -> 256
    vecs[7]  = '{11'd0,    11'd2047, 1'b1, 2, G_WR};
    vecs[8]  = '{11'd0,    11'd64,   1'b0, 0, G_WR};    // write alone repeats
    vecs[9]  = '{11'd500,  11'd0,    1'b1, 2, G_RD};
    vecs[10] = '{11'd0,    11'd63,   1'b1, 0, G_RD};    // read alone repeats

    init_calib_complete = 1'b0; fifo_init_ok = 1'b1;
    wr_load = 1'b0; rd_load = 1'b0; rd_enable = 1'b0;
    wfifo_rcount = 11'd64; rfifo_wcount = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    wr_ptr_m = 28'(WB); rd_ptr_m = 28'(RB);

    repeat (3) tick();
    check("rst_app_en", 32'(app_en), 32'd0);
    check("rst_app_cmd", 32'(app_cmd), 32'd1);
    check("rst_wfifo_rden", 32'(wfifo_rden), 32'd0);
    check("rst_rfifo_wren", 32'(rfifo_wren), 32'd0);
    check("rst_wdf", 32'({app_wdf_wren, app_wdf_end}), 32'd0);
    check("rst_app_addr", 32'(app_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Writes are pending, but calibration is not done: nothing is issued.
    repeat (5) tick();
    check("calib_low_app_en", 32'(app_en), 32'd0);
    check("calib_low_busy", 32'(busy), 32'd0);
    wfifo_rcount = '0;
    init_calib_complete = 1'b1;
    repeat (3) tick();
    check("idle_app_en", 32'(app_en), 32'd0);

    for (int i = 0; i < 11; i++) begin
      wfifo_rcount = vecs[i].rcount;
      rfifo_wcount = vecs[i].wcount;
      rd_enable    = vecs[i].rd_en;
      if (vecs[i].exp == G_WR) push_wr(BL);
      if (vecs[i].exp == G_RD) push_rd(BL);
      if (vecs[i].exp == G_NONE) begin
        repeat (6) tick();
        check($sformatf("vec%0d_no_grant", i), 32'(busy | app_en), 32'd0);
      end else begin
        do_burst(vecs[i].exp, vecs[i].mode, $sformatf("vec%0d", i));
      end
    end

    // Round-robin under continuous requests: last grant was READ -> W, R, W.
    push_wr(BL); push_rd(BL); push_wr(BL);
    wfifo_rcount = 11'd200; rd_enable = 1'b1; rfifo_wcount = '0;
    for (int b = 0; b < 3; b++) begin
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
        tick();
        got = busy;
      end
      check($sformatf("rr%0d_grant", b), 32'(got), 32'd1);
      check($sformatf("rr%0d_cmd", b), 32'(app_cmd), (b == 1) ? 32'd1 : 32'd0);
      if (b == 2) begin
        wfifo_rcount = '0;
        rd_enable = 1'b0;
      end
      n = 0;
      while (busy && n < 3000) begin
        tick();
        n++;
      end
      check($sformatf("rr%0d_done", b), 32'(busy), 32'd0);
    end

    // rd_load during a read burst: that burst stays contiguous, and the next
    // one starts at RD_BASE.
    push_rd(BL);
    rd_enable = 1'b1;
    fork
      do_burst(G_RD, 1, "rd_restart_cur");
      begin
        repeat (10) tick();
        rd_load = 1'b1;
        repeat (4) tick();
        rd_load = 1'b0;
      end
    join
    rd_ptr_m = 28'(RB);
    push_rd(BL);
    rd_enable = 1'b1;
    do_burst(G_RD, 0, "rd_restart_next");

    // Calibration loss mid-write: abort at once, and resume at the same address.
    push_wr(BL);
    wr0 = wr_acc_cnt;
    wfifo_rcount = 11'd64;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      got = busy;
    end
    check("abort_grant", 32'(got), 32'd1);
    wfifo_rcount = '0;
    repeat (10) tick();
    init_calib_complete = 1'b0;
    tick();
    check("abort_app_en", 32'(app_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("abort_still_idle", 32'(app_en), 32'd0);
    k = wr_acc_cnt - wr0;
    check("abort_partial", 32'(k > 0 && k < int'(BL)), 32'd1);
    init_calib_complete = 1'b1;
    push_wr(k);
    wfifo_rcount = 11'd64;
    do_burst(G_WR, 0, "abort_resume");

    // wr_load while idle: the next write burst starts at WR_BASE.
    wr_load = 1'b1;
    repeat (4) tick();
    wr_load = 1'b0;
    repeat (3) tick();
    wr_ptr_m = 28'(WB);
    push_wr(BL);
    wfifo_rcount = 11'd64;
    do_burst(G_WR, 2, "wr_restart");

    // Reset in the middle of a write burst.
    push_wr(BL);
    wfifo_rcount = 11'd64;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      got = busy;
    end
    check("rst_mid_grant", 32'(got), 32'd1);
    wfifo_rcount = '0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_app_en", 32'(app_en), 32'd0);
    check("rst_mid_rden", 32'(wfifo_rden), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_addr", 32'(app_addr), 32'd0);
    exp_wr_q.delete();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
